// File: rtl/vocab_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vocab_port_arbiter
// Desc     : Round-robin, scan-locked arbiter sharing one vocab memory read
//            port among NUM_REQ matchers; read data is routed back through a
//            tag pipeline. Define ARB_TIMEOUT_EN to add a stalled-owner
//            watchdog (parameter TIMEOUT, output timeout_err).
// Revision : 1.0 - initial release
// ============================================================================
module vocab_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_LATENCY = 1
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 8
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              mem_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] mem_rdata,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0] rsp_data,
    output logic                              busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                              timeout_err
`endif
);

    localparam int                c_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_ID_W-1:0] c_ID_ONE  = c_ID_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_nxt_state;
    logic [c_ID_W-1:0]       r_owner;
    logic [c_ID_W-1:0]       w_nxt_owner;
    logic [c_ID_W-1:0]       r_rr_ptr;
    logic [c_ID_W-1:0]       w_nxt_rr_ptr;
    logic [c_ID_W-1:0]       w_pick;
    logic [c_ID_W-1:0]       w_scan;
    logic                    w_any_req;
    logic                    w_accept;
    logic                    w_force_rel;
    logic [NUM_REQ-1:0]      w_nxt_gnt;
    logic                    w_nxt_mem_en;
    logic [ADDR_WIDTH-1:0]   w_nxt_mem_addr;
    logic [ADDR_WIDTH-1:0]   w_addr [NUM_REQ];
    logic [MEM_LATENCY:0]    r_tag_vld;
    logic [c_ID_W-1:0]       r_tag_id [MEM_LATENCY+1];

    function automatic logic [c_ID_W-1:0] f_wrap_inc(input logic [c_ID_W-1:0] id);
        return (id == c_LAST_ID) ? '0 : id + c_ID_ONE;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_scan    = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any_req && req[w_scan]) begin
                w_any_req = 1'b1;
                w_pick    = w_scan;
            end
            w_scan = f_wrap_inc(w_scan);
        end
    end

    assign w_accept = (r_state == S_LOCK) && req[r_owner] && gnt[r_owner];

`ifdef ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    assign w_force_rel = (r_state == S_LOCK) && !w_accept &&
                         (r_to_cnt == c_TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= w_force_rel;
            if ((r_state != S_LOCK) || w_accept || w_force_rel) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
        end
    end
`else
    assign w_force_rel = 1'b0;
`endif

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_owner    = r_owner;
        w_nxt_rr_ptr   = r_rr_ptr;
        w_nxt_gnt      = gnt;
        w_nxt_mem_en   = 1'b0;
        w_nxt_mem_addr = mem_addr;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_nxt_state       = S_LOCK;
                    w_nxt_owner       = w_pick;
                    w_nxt_rr_ptr      = f_wrap_inc(w_pick);
                    w_nxt_gnt         = '0;
                    w_nxt_gnt[w_pick] = 1'b1;
                end
            end
            S_LOCK: begin
                if (w_accept) begin
                    w_nxt_mem_en   = 1'b1;
                    w_nxt_mem_addr = w_addr[r_owner];
                end
                // Grant drops on the final access; arbitration resumes next edge.
                if ((w_accept && req_last[r_owner]) || w_force_rel) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_gnt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            gnt      <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_owner  <= w_nxt_owner;
            r_rr_ptr <= w_nxt_rr_ptr;
            gnt      <= w_nxt_gnt;
            mem_en   <= w_nxt_mem_en;
            mem_addr <= w_nxt_mem_addr;
        end
    end

    // Tags ride alongside the read so data returns to the issuing matcher
    // even after the grant has moved to someone else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i <= MEM_LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= r_owner;
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            rsp_valid <= '0;
            if (r_tag_vld[MEM_LATENCY]) begin
                rsp_valid[r_tag_id[MEM_LATENCY]] <= 1'b1;
                rsp_data                         <= mem_rdata;
            end
        end
    end

    assign busy = (r_state == S_LOCK) || (|r_tag_vld);

endmodule
`default_nettype wire

// File: tb/tb_vocab_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vocab_port_arbiter
// Desc     : Directed + random bench for vocab_port_arbiter with a response
//            scoreboard and a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vocab_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int WL  = 3;
    localparam int DW  = 8;
    localparam int LAT = 1;
    localparam int WW  = WL * DW;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N-1:0]    gnt;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_rdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [WW-1:0]   rsp_data;
    logic            busy;
`ifdef ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    vocab_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .WORD_LENGTH(WL),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_last  (req_last),
        .gnt       (gnt),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] f_word(input logic [AW-1:0] a);
        logic [7:0] v_a;
        v_a = {4'h0, a};
        return {8'h40 + v_a, 8'h60 + v_a, 8'h70 + v_a};
    endfunction

    // Single-port vocab memory, one cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= f_word(mem_addr);
    end

    typedef struct {
        int            due;
        int            id;
        logic [WW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec      = 0;
    int            n_err      = 0;
    int            cyc        = 0;
    int            m_owner    = -1;
    int            m_rr       = 0;
    logic          m_mem_en   = 1'b0;
    logic [AW-1:0] m_mem_addr = '0;
    bit            rand_mode  = 1'b0;

    // Matcher agents: each sweeps a_left addresses starting at a_addr.
    bit a_act    [N];
    bit a_was_hi [N];
    int a_addr   [N];
    int a_left   [N];
    int a_stall  [N];
    int a_stall_at [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_scan(input int i, input int s, input int n);
        a_act[i]      = 1'b1;
        a_addr[i]     = s % 16;
        a_left[i]     = n;
        a_stall[i]    = 0;
        a_stall_at[i] = -1;
    endtask

    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (a_act[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        if (m_owner >= 0) return 1'b1;
        foreach (sb_q[i]) if (sb_q[i].due > cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                if (!a_act[i] && $urandom_range(0, 3) == 0)
                    start_scan(i, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
                else if (a_act[i] && a_was_hi[i] && a_stall[i] == 0 && $urandom_range(0, 7) == 0)
                    a_stall[i] = int'($urandom_range(1, 3));
            end
            if (a_act[i] && a_stall[i] == 0) begin
                req[i]                = 1'b1;
                req_addr[i*AW +: AW]  = AW'(a_addr[i]);
                req_last[i]           = (a_left[i] == 1);
            end else begin
                if (a_stall[i] > 0) a_stall[i]--;
                req[i]                = 1'b0;
                req_addr[i*AW +: AW]  = AW'($urandom);
                req_last[i]           = 1'($urandom_range(0, 1));
            end
            a_was_hi[i] = req[i];
        end
    endtask

    // Reference: round-robin pick among requesters, owner keeps the port
    // until its req_last access, every accepted access yields one response.
    task automatic model_step();
        cyc++;
        if (m_owner < 0) begin
            m_mem_en = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            if (m_owner >= 0) m_rr = (m_owner + 1) % N;
        end else if (req[m_owner]) begin
            int o = m_owner;
            m_mem_en   = 1'b1;
            m_mem_addr = req_addr[o*AW +: AW];
            sb_q.push_back('{due: cyc + LAT + 1, id: o, data: f_word(m_mem_addr)});
            if (req_last[o]) m_owner = -1;
            a_addr[o] = (a_addr[o] + 1) % 16;
            a_left[o]--;
            if (a_left[o] == 0) a_act[o] = 1'b0;
            else if (a_left[o] == a_stall_at[o]) a_stall[o] = 3;
        end else begin
            m_mem_en = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("mem_en", 32'(mem_en), 32'(m_mem_en));
        check("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
        check("busy", 32'(busy), 32'(m_busy()));
`ifdef ARB_TIMEOUT_EN
        check("timeout_err", 32'(timeout_err), 32'd0);
`endif
    endtask

    task automatic step();
        drive_inputs();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        if (rst_n) check_outputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((any_active() || m_owner >= 0 || sb_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
            sb_q.delete();
        end
        step();
    endtask

    // Response monitor: pops the scoreboard whenever the DUT strobes rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL rsp_missing: got none, expected id %0d data %h at cycle %0d", e.id, e.data, e.due);
            end
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b, expected none (cycle %0d)", rsp_valid, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_cycle", cyc, e.due);
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a_act[i]      = 1'b0;
            a_was_hi[i]   = 1'b0;
            a_addr[i]     = 0;
            a_left[i]     = 0;
            a_stall[i]    = 0;
            a_stall_at[i] = -1;
        end
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // All four matchers, two accesses each
        for (int i = 0; i < N; i++) start_scan(i, 4 * i, 2);
        drain();

        // Single matcher 2 sweeping 3..5
        start_scan(2, 3, 3);
        drain();

        // Owner 1 finishing with 0 and 2 pending
        start_scan(1, 8, 3);
        repeat (2) step();
        start_scan(0, 1, 2);
        start_scan(2, 10, 2);
        drain();

        // Owner 1 pauses three cycles mid-scan while 0 waits
        start_scan(1, 5, 5);
        a_stall_at[1] = 3;
        repeat (2) step();
        start_scan(0, 12, 2);
        drain();

        // Asynchronous reset with responses in flight
        start_scan(2, 0, 8);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) begin
            a_act[i]   = 1'b0;
            a_stall[i] = 0;
        end
        sb_q.delete();
        m_owner    = -1;
        m_rr       = 0;
        m_mem_en   = 1'b0;
        m_mem_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            step();
            check("rsp_after_rst", 32'(rsp_valid), 32'd0);
        end

        // Random traffic
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        drain();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
